// File: rtl/branch_resolve_unit_pkg.sv
// Shared RV32I control-flow definitions for the branch resolve unit.
// Contents: opcode/funct3 encodings for BRANCH/JAL/JALR, the 2-bit branch-history
// counter encoding, and the saturating counter update used by the BHT.
package branch_resolve_unit_pkg;

  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  // Bimodal counter: MSB is the predicted direction.
  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  // Saturating step towards the observed outcome.
  function automatic logic [1:0] ctr_next(logic [1:0] ctr, logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == CtrSt) ? ctr : ctr + 2'd1;
    end else begin
      res = (ctr == CtrSnt) ? ctr : ctr - 2'd1;
    end
    return res;
  endfunction

  // funct3 010/011 under the BRANCH opcode are not control-flow operations.
  function automatic logic is_cond_f3(logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bundle between the pipeline (master) and the branch resolve unit (slave).
//  IF side : if_pc -> if_pred_taken
//  EX side : ex_valid, ex_bolha, ex_opcode, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm,
//            ex_pred_taken
//  Results : br_taken, flush, redirect_pc, stat_branches, stat_mispred
interface branch_resolve_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic             ex_valid;
  logic             ex_bolha;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic             ex_pred_taken;
  logic             br_taken;
  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispred;

  modport master (
    output if_pc, ex_valid, ex_bolha, ex_opcode, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm,
           ex_pred_taken,
    input  if_pred_taken, br_taken, flush, redirect_pc, stat_branches, stat_mispred
  );

  modport slave (
    input  if_pc, ex_valid, ex_bolha, ex_opcode, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm,
           ex_pred_taken,
    output if_pred_taken, br_taken, flush, redirect_pc, stat_branches, stat_mispred
  );
endinterface

// File: rtl/bht_counter_array.sv
// Bimodal branch-history table of 2-bit saturating counters.
//  clk_i, rst_i  : clock, synchronous active-high reset (all counters <= CTR_RESET)
//  rd_idx_i      : lookup index, rd_ctr_o is the stored counter (combinational, no bypass)
//  wr_en_i       : update counter wr_idx_i one step towards wr_taken_i
module bht_counter_array
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ENTRIES   = 64,
  parameter logic [1:0]  CTR_RESET = 2'b01
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
  output logic [1:0]                 rd_ctr_o,
  input  logic                       wr_en_i,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx_i,
  input  logic                       wr_taken_i
);

  logic [1:0] ctr_q [ENTRIES];

  // Reads return the pre-update value when rd_idx_i == wr_idx_i.
  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= ctr_next(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves BRANCH/JAL/JALR in EX, predicts direction for IF from a
// bimodal BHT, and registers flush/redirect one cycle after resolve.
//  clk, rst : clock, synchronous active-high reset
//  bus      : branch_resolve_if slave (IF lookup, EX operands, registered results, stats)
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  CTR_RESET   = 2'b01,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic             is_branch, is_jal, is_jalr, is_ctl, resolve;
  logic             cond, taken, mispredict;
  logic [XLEN-1:0]  br_target, jalr_target, fallthrough, next_pc;
  logic [1:0]       rd_ctr;

  logic             br_taken_q, br_taken_d;
  logic             flush_q, flush_d;
  logic             shadow_q, shadow_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mp_q, stat_mp_d;

  logic             unused_if_pc;

  // Only the index bits of the fetch PC participate in the lookup.
  assign unused_if_pc = ^{bus.if_pc[XLEN-1:IdxW+2], bus.if_pc[1:0]};

  bht_counter_array #(
    .ENTRIES   (BHT_ENTRIES),
    .CTR_RESET (CTR_RESET)
  ) u_bht (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_idx_i   (bus.if_pc[2 +: IdxW]),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (resolve & is_branch),
    .wr_idx_i   (bus.ex_pc[2 +: IdxW]),
    .wr_taken_i (cond)
  );

  assign is_branch = (bus.ex_opcode == OpcBranch) && is_cond_f3(bus.ex_funct3);
  assign is_jal    = (bus.ex_opcode == OpcJal);
  assign is_jalr   = (bus.ex_opcode == OpcJalr);
  assign is_ctl    = is_branch | is_jal | is_jalr;
  // The instruction behind a flush is wrong-path; shadow masks it for one cycle.
  assign resolve   = bus.ex_valid & ~bus.ex_bolha & ~shadow_q & is_ctl;

  always_comb begin
    cond = 1'b0;
    case (bus.ex_funct3)
      F3Beq:   cond = (bus.ex_rs1 == bus.ex_rs2);
      F3Bne:   cond = (bus.ex_rs1 != bus.ex_rs2);
      F3Blt:   cond = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      F3Bge:   cond = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      F3Bltu:  cond = (bus.ex_rs1 <  bus.ex_rs2);
      F3Bgeu:  cond = (bus.ex_rs1 >= bus.ex_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign br_target   = bus.ex_pc + bus.ex_imm;
  assign jalr_target = (bus.ex_rs1 + bus.ex_imm) & ~XLEN'(1);
  assign fallthrough = bus.ex_pc + XLEN'(4);
  assign taken       = is_branch ? cond : (is_jal | is_jalr);
  assign next_pc     = !taken ? fallthrough : (is_jalr ? jalr_target : br_target);

  always_comb begin
    mispredict = 1'b0;
    if (is_branch) begin
      mispredict = (taken != bus.ex_pred_taken);
    end else if (is_jal) begin
      // A predicted JAL was already redirected by ID.
      mispredict = ~bus.ex_pred_taken;
    end else if (is_jalr) begin
      mispredict = 1'b1;
    end
  end

  always_comb begin
    br_taken_d    = resolve & taken;
    flush_d       = resolve & mispredict;
    shadow_d      = flush_d;
    redirect_pc_d = resolve ? next_pc : redirect_pc_q;
    stat_br_d     = stat_br_q;
    stat_mp_d     = stat_mp_q;
    if (resolve && is_branch && !(&stat_br_q)) begin
      stat_br_d = stat_br_q + CNT_W'(1);
    end
    if (flush_d && !(&stat_mp_q)) begin
      stat_mp_d = stat_mp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_q    <= 1'b0;
      flush_q       <= 1'b0;
      shadow_q      <= 1'b0;
      redirect_pc_q <= '0;
      stat_br_q     <= '0;
      stat_mp_q     <= '0;
    end else begin
      br_taken_q    <= br_taken_d;
      flush_q       <= flush_d;
      shadow_q      <= shadow_d;
      redirect_pc_q <= redirect_pc_d;
      stat_br_q     <= stat_br_d;
      stat_mp_q     <= stat_mp_d;
    end
  end

  assign bus.if_pred_taken = rd_ctr[1];
  assign bus.br_taken      = br_taken_q;
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.stat_branches = stat_br_q;
  assign bus.stat_mispred  = stat_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN=32, 64-entry BHT, 4-bit statistics).
module tb_branch_resolve_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam logic [6:0] OB = 7'h63;
  localparam logic [6:0] OJ = 7'h6F;
  localparam logic [6:0] OR = 7'h67;
  localparam int unsigned STAT_MAX = (1 << CNT_W) - 1;
  localparam int NV = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (64),
    .CTR_RESET   (2'b01),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        e_flush;
    logic        e_taken;
    logic [31:0] e_rdr;
  } vec_t;

  vec_t v [NV];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_br = 0;
  int exp_mp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_stats();
    chk("stat_branches", 32'(bus.stat_branches), 32'(exp_br));
    chk("stat_mispred", 32'(bus.stat_mispred), 32'(exp_mp));
  endtask

  function automatic int sat(input int x);
    return (x >= int'(STAT_MAX)) ? int'(STAT_MAX) : x + 1;
  endfunction

  task automatic idle();
    bus.ex_valid = 1'b0;
    bus.ex_bolha = 1'b0;
    bus.ex_opcode = 7'h13;
    bus.ex_funct3 = 3'b000;
    bus.ex_rs1 = '0;
    bus.ex_rs2 = '0;
    bus.ex_pc = '0;
    bus.ex_imm = '0;
    bus.ex_pred_taken = 1'b0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                       input logic pred);
    bus.ex_valid = 1'b1;
    bus.ex_bolha = 1'b0;
    bus.ex_opcode = op;
    bus.ex_funct3 = f3;
    bus.ex_rs1 = rs1;
    bus.ex_rs2 = rs2;
    bus.ex_pc = pc;
    bus.ex_imm = imm;
    bus.ex_pred_taken = pred;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        op  f3    rs1           rs2           pc            imm           pr fl tk redirect
    v[0]  = '{OB, 3'd4, 32'hFFFFFFFF, 32'h1,        32'h204,      32'h10,       0, 1, 1, 32'h214};
    v[1]  = '{OB, 3'd6, 32'hFFFFFFFF, 32'h1,        32'h208,      32'h10,       0, 0, 0, 32'h20C};
    v[2]  = '{OB, 3'd5, 32'h1,        32'hFFFFFFFF, 32'h20C,      32'hFFFFFFF8, 1, 0, 1, 32'h204};
    v[3]  = '{OB, 3'd7, 32'h1,        32'hFFFFFFFF, 32'h210,      32'h40,       1, 1, 0, 32'h214};
    v[4]  = '{OB, 3'd1, 32'h3,        32'h3,        32'h214,      32'h40,       0, 0, 0, 32'h218};
    v[5]  = '{OJ, 3'd0, 32'h0,        32'h0,        32'h300,      32'h100,      1, 0, 1, 32'h400};
    v[6]  = '{OJ, 3'd0, 32'h0,        32'h0,        32'h300,      32'h100,      0, 1, 1, 32'h400};
    v[7]  = '{OR, 3'd0, 32'h1001,     32'h0,        32'h500,      32'h2,        1, 1, 1, 32'h1002};
    v[8]  = '{OR, 3'd0, 32'hFFFFFFF0, 32'h0,        32'h504,      32'h20,       0, 1, 1, 32'h10};
    v[9]  = '{OB, 3'd2, 32'h5,        32'h5,        32'h600,      32'h40,       0, 0, 0, 32'h10};
    v[10] = '{OB, 3'd0, 32'h0,        32'h0,        32'hFFFFFFF0, 32'h20,       1, 0, 1, 32'h10};
    v[11] = '{OB, 3'd4, 32'h1,        32'hFFFFFFFF, 32'h220,      32'h40,       1, 1, 0, 32'h224};

    // Reset state
    rst = 1'b1;
    idle();
    bus.if_pc = 32'h100;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_br_taken", 32'(bus.br_taken), 32'h0);
    chk("rst_redirect", bus.redirect_pc, 32'h0);
    chk("rst_pred", 32'(bus.if_pred_taken), 32'h0);
    chk_stats();

    // BEQ taken, mispredicted; lookup of the same index sees the old counter
    drive(OB, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    #1;
    chk("same_cycle_pred_old", 32'(bus.if_pred_taken), 32'h0);
    tick();
    exp_br = sat(exp_br);
    exp_mp = sat(exp_mp);
    chk("beq_flush", 32'(bus.flush), 32'h1);
    chk("beq_redirect", bus.redirect_pc, 32'h120);
    chk("beq_taken", 32'(bus.br_taken), 32'h1);
    chk("beq_pred_after", 32'(bus.if_pred_taken), 32'h1);
    chk_stats();
    idle();
    tick();
    chk("beq_flush_clear", 32'(bus.flush), 32'h0);

    // Table vectors, each followed by an idle cycle so no vector lands in a shadow
    for (int i = 0; i < NV; i++) begin
      drive(v[i].op, v[i].f3, v[i].rs1, v[i].rs2, v[i].pc, v[i].imm, v[i].pred);
      tick();
      chk($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(v[i].e_flush));
      chk($sformatf("v%0d_taken", i), 32'(bus.br_taken), 32'(v[i].e_taken));
      chk($sformatf("v%0d_redirect", i), bus.redirect_pc, v[i].e_rdr);
      if (v[i].op == OB && v[i].f3 != 3'd2 && v[i].f3 != 3'd3) exp_br = sat(exp_br);
      if (v[i].e_flush) exp_mp = sat(exp_mp);
      chk_stats();
      idle();
      tick();
      chk($sformatf("v%0d_flush_clear", i), 32'(bus.flush), 32'h0);
    end

    // Counter saturation: three taken then two not-taken at one pc
    bus.if_pc = 32'h180;
    drive(OB, 3'd1, 32'd1, 32'd2, 32'h180, 32'h40, 1'b1);
    #1;
    chk("sat_pred0", 32'(bus.if_pred_taken), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_br = sat(exp_br);
      chk($sformatf("sat_inc%0d_flush", i), 32'(bus.flush), 32'h0);
      chk($sformatf("sat_inc%0d_pred", i), 32'(bus.if_pred_taken), 32'h1);
    end
    chk_stats();
    for (int i = 0; i < 2; i++) begin
      drive(OB, 3'd1, 32'd7, 32'd7, 32'h180, 32'h40, 1'b1);
      tick();
      exp_br = sat(exp_br);
      exp_mp = sat(exp_mp);
      chk($sformatf("sat_dec%0d_flush", i), 32'(bus.flush), 32'h1);
      chk($sformatf("sat_dec%0d_redirect", i), bus.redirect_pc, 32'h184);
      chk($sformatf("sat_dec%0d_pred", i), 32'(bus.if_pred_taken), (i == 0) ? 32'h1 : 32'h0);
      idle();
      tick();
    end
    chk_stats();

    // Mispredict followed back-to-back by JALR: JALR sits in the shadow
    drive(OB, 3'd0, 32'd9, 32'd9, 32'h140, 32'h60, 1'b0);
    tick();
    exp_br = sat(exp_br);
    exp_mp = sat(exp_mp);
    chk("sh_flush", 32'(bus.flush), 32'h1);
    chk("sh_redirect", bus.redirect_pc, 32'h1A0);
    drive(OR, 3'd0, 32'h2000, 32'h0, 32'h1A0, 32'h0, 1'b0);
    tick();
    chk("sh_jalr_flush", 32'(bus.flush), 32'h0);
    chk("sh_jalr_taken", 32'(bus.br_taken), 32'h0);
    chk("sh_jalr_redirect", bus.redirect_pc, 32'h1A0);
    chk_stats();
    // Shadow cleared: the same mispredict flushes again, then a shadowed branch
    drive(OB, 3'd0, 32'd9, 32'd9, 32'h140, 32'h60, 1'b0);
    tick();
    exp_br = sat(exp_br);
    exp_mp = sat(exp_mp);
    chk("sh2_flush", 32'(bus.flush), 32'h1);
    drive(OB, 3'd0, 32'd1, 32'd1, 32'h1C0, 32'h8, 1'b0);
    tick();
    chk("sh2_br_flush", 32'(bus.flush), 32'h0);
    chk_stats();
    bus.if_pc = 32'h1C0;
    #1;
    chk("sh2_no_bht_update", 32'(bus.if_pred_taken), 32'h0);

    // Bubble on a BRANCH: no resolve
    drive(OB, 3'd0, 32'd1, 32'd1, 32'h1C0, 32'h8, 1'b0);
    bus.ex_bolha = 1'b1;
    tick();
    chk("bolha_flush", 32'(bus.flush), 32'h0);
    chk("bolha_pred", 32'(bus.if_pred_taken), 32'h0);
    chk_stats();
    idle();
    tick();

    // Drive stat_mispred into saturation with JALRs
    for (int i = 0; i < 8; i++) begin
      drive(OR, 3'd0, 32'h1001, 32'h0, 32'h500, 32'h2, 1'b0);
      tick();
      exp_mp = sat(exp_mp);
      chk($sformatf("mp%0d_flush", i), 32'(bus.flush), 32'h1);
      chk($sformatf("mp%0d_stat", i), 32'(bus.stat_mispred), 32'(exp_mp));
      idle();
      tick();
    end
    chk("mp_saturated", 32'(bus.stat_mispred), 32'hF);

    // Reset on the cycle a flush would be set
    bus.if_pc = 32'h140;
    #1;
    chk("pre_rst_pred", 32'(bus.if_pred_taken), 32'h1);
    drive(OB, 3'd0, 32'd4, 32'd4, 32'h140, 32'h60, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    exp_br = 0;
    exp_mp = 0;
    chk("rst2_flush", 32'(bus.flush), 32'h0);
    chk("rst2_taken", 32'(bus.br_taken), 32'h0);
    chk("rst2_redirect", bus.redirect_pc, 32'h0);
    chk("rst2_pred", 32'(bus.if_pred_taken), 32'h0);
    chk_stats();

    // First branch after reset resolves normally
    drive(OB, 3'd0, 32'd4, 32'd4, 32'h100, 32'h8, 1'b0);
    tick();
    exp_br = sat(exp_br);
    exp_mp = sat(exp_mp);
    chk("post_rst_flush", 32'(bus.flush), 32'h1);
    chk("post_rst_redirect", bus.redirect_pc, 32'h108);
    chk_stats();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
